// File: rtl/ram_read_arbiter_pkg.sv
// Shared types and constants for the RAM read arbiter.
package ram_read_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARB,
        ST_XFER,
        ST_DISCARD
    } arb_state_e;

    localparam int DEF_BURST_LEN = 256;
    localparam int REQ_VU        = 0;
    localparam int REQ_AUX       = 1;

endpackage

// File: rtl/ram_read_arbiter_rr.sv
// Combinational round-robin pick: search starts one past the last grant.
module rr_arbiter
    import ram_read_arbiter_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int LG_W  = 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [LG_W-1:0]  i_last,
    output logic [N_REQ-1:0] o_gnt,
    output logic [LG_W-1:0]  o_idx
);

    logic w_found;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (!w_found && i_req[j] &&
                    (j == (int'(i_last) + k) % N_REQ)) begin
                    o_gnt[j] = 1'b1;
                    o_idx    = LG_W'(j);
                    w_found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ram_read_arbiter.sv
// Hands complete RAM buffers to one requester at a time, draining
// buffers nobody wants and counting those drops.
module ram_read_arbiter
    import ram_read_arbiter_pkg::*;
#(
    parameter int N_REQ     = 2,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int CNT_W     = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DATA_W-1:0] ram_read_data_i,
    input  logic              ram_read_valid_i,
    output logic              ram_read_ready_o,
    input  logic              ram_buffer_ready_i,
    input  logic [N_REQ-1:0]  req_i,
    output logic [N_REQ-1:0]  gnt_o,
    output logic [N_REQ-1:0]  buffer_ready_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [N_REQ-1:0]  rd_valid_o,
    input  logic [N_REQ-1:0]  rd_ready_i,
    output logic              busy_o,
    output logic [CNT_W-1:0]  drop_count_o
);

    localparam int WC_W = $clog2(BURST_LEN + 1);
    localparam int LG_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_e       r_state, w_state_nxt;
    logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
    logic [N_REQ-1:0] r_req, w_req_nxt;
    logic [LG_W-1:0]  r_last, w_last_nxt;
    logic [WC_W-1:0]  r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0] r_drop, w_drop_nxt;
    logic [N_REQ-1:0] w_pick;
    logic [LG_W-1:0]  w_pick_idx;
    logic             w_xfer;
    logic             w_accept;
    logic             w_last_word;

    // Arbitrate on the request snapshot taken in IDLE, not the live req_i
    rr_arbiter #(
        .N_REQ (N_REQ),
        .LG_W  (LG_W)
    ) u_rr (
        .i_req  (r_req),
        .i_last (r_last),
        .o_gnt  (w_pick),
        .o_idx  (w_pick_idx)
    );

    assign w_xfer           = (r_state == ST_XFER);
    assign ram_read_ready_o = (r_state == ST_DISCARD) ||
                              (w_xfer && |(rd_ready_i & r_gnt));
    assign rd_valid_o       = (w_xfer && ram_read_valid_i) ? r_gnt : '0;
    assign buffer_ready_o   = w_xfer ? r_gnt : '0;
    assign rd_data_o        = ram_read_data_i;
    assign gnt_o            = r_gnt;
    assign busy_o           = (r_state != ST_IDLE);
    assign drop_count_o     = r_drop;

    assign w_accept    = ram_read_valid_i && ram_read_ready_o;
    assign w_last_word = w_accept && (r_cnt == WC_W'(BURST_LEN - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_req_nxt   = r_req;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_drop_nxt  = r_drop;
        unique case (r_state)
            ST_IDLE: begin
                if (ram_buffer_ready_i) begin
                    w_req_nxt   = req_i;
                    w_state_nxt = (|req_i) ? ST_ARB : ST_DISCARD;
                end
            end
            ST_ARB: begin
                w_gnt_nxt   = w_pick;
                w_last_nxt  = w_pick_idx;
                w_state_nxt = ST_XFER;
            end
            ST_XFER: begin
                if (w_accept) w_cnt_nxt = r_cnt + WC_W'(1);
                if (w_last_word) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_gnt_nxt   = '0;
                end else if (!(|(req_i & r_gnt))) begin
                    w_state_nxt = ST_DISCARD;
                    w_gnt_nxt   = '0;
                end
            end
            ST_DISCARD: begin
                if (w_accept) w_cnt_nxt = r_cnt + WC_W'(1);
                if (w_last_word) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    if (!(&r_drop)) w_drop_nxt = r_drop + CNT_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_req   <= '0;
            r_last  <= LG_W'(N_REQ - 1);
            r_cnt   <= '0;
            r_drop  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_req   <= w_req_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
            r_drop  <= w_drop_nxt;
        end
    end

endmodule

// File: doc/ram_read_arbiter.md
RAM_READ_ARBITER -- requirements
Module: ram_read_arbiter

Interface
REQ-001 Parameter N_REQ, default 2, number of read requesters (VU meter = index 0, secondary consumer = index 1).
REQ-002 Parameter DATA_W, default 32, RAM word width.
REQ-003 Parameter BURST_LEN, default 256, words per RAM buffer.
REQ-004 Parameter CNT_W, default 16, drop counter width.
REQ-005 clk_i  in  1  single system clock; all logic on its rising edge.
REQ-006 rst_ni  in  1  asynchronous active-low reset.
REQ-007 ram_read_data_i  in  DATA_W  RAM read word.
REQ-008 ram_read_valid_i  in  1  RAM word valid.
REQ-009 ram_read_ready_o  out  1  arbiter/consumer accepts RAM word.
REQ-010 ram_buffer_ready_i  in  1  RAM holds a complete buffer.
REQ-011 req_i  in  N_REQ  requester wants the next buffer (level).
REQ-012 gnt_o  out  N_REQ  one-hot grant, held for a whole buffer.
REQ-013 buffer_ready_o  out  N_REQ  per-requester buffer-ready, asserted only to the granted index.
REQ-014 rd_data_o  out  DATA_W  broadcast copy of ram_read_data_i.
REQ-015 rd_valid_o  out  N_REQ  per-requester word valid.
REQ-016 rd_ready_i  in  N_REQ  per-requester word accept.
REQ-017 busy_o  out  1  high in any state other than IDLE.
REQ-018 drop_count_o  out  CNT_W  buffers drained with no consumer; saturates at all-ones.

Function
REQ-019 States: IDLE, ARB, XFER, DISCARD.
REQ-020 IDLE -> ARB when ram_buffer_ready_i=1 and req_i!=0; IDLE -> DISCARD when ram_buffer_ready_i=1 and req_i=0; otherwise stay.
REQ-021 ARB lasts exactly one cycle: register one-hot grant chosen round-robin, then -> XFER.
REQ-022 Round-robin: search starts at index (last_grant+1) mod N_REQ; after reset, last_grant = N_REQ-1, so index 0 has first priority.
REQ-023 XFER: ram_read_ready_o = rd_ready_i[g], rd_valid_o[g] = ram_read_valid_i, buffer_ready_o[g] = 1, where g is the granted index; all other bits are 0.
REQ-024 DISCARD: ram_read_ready_o = 1; rd_valid_o, buffer_ready_o and gnt_o are all 0.
REQ-025 IDLE and ARB: ram_read_ready_o = 0; rd_valid_o = 0; buffer_ready_o = 0.
REQ-026 A word is accepted when ram_read_valid_i & ram_read_ready_o; the word counter increments on each accepted word.
REQ-027 The handshake path is combinational (zero added latency); rd_data_o = ram_read_data_i at all times.
REQ-028 On the cycle the BURST_LEN-th word is accepted: XFER/DISCARD -> IDLE, word counter clears, gnt_o clears on the next cycle.
REQ-029 If req_i[g] falls mid-XFER: -> DISCARD on the next cycle, keeping the word count; the buffer is drained and drop_count_o increments on completion.
REQ-030 drop_count_o increments once per buffer completed in DISCARD; no increment when already at all-ones.
REQ-031 ram_buffer_ready_i is sampled only in IDLE; its value is ignored in other states.
REQ-032 req_i changes during ARB do not alter the grant being registered.
REQ-033 last_grant updates in ARB only; DISCARD does not change it.
REQ-034 The word counter is clog2(BURST_LEN+1) bits wide with no wrap; reaching BURST_LEN always ends the buffer.

Reset
REQ-035 Asynchronous assertion of rst_ni=0 forces state IDLE, gnt_o=0, word counter=0, last_grant=N_REQ-1, drop_count_o=0 and busy_o=0.
REQ-036 All combinational outputs evaluate to their IDLE values during reset.
REQ-037 Reset mid-transfer abandons the buffer; no completion is flagged.

Structure
REQ-038 The shared package holds the state enum (arb_state_e), the BURST_LEN default and the requester index constants (REQ_VU=0, REQ_AUX=1).
REQ-039 One sub-module, rr_arbiter (combinational round-robin pick from req vector and last_grant); everything else is flat.

Verification
REQ-040 req_i=01, buffer ready, rd_ready_i[0]=1 -> gnt_o=01, 256 words delivered to index 0, rd_valid_o[1]=0 throughout, return to IDLE after word 256.
REQ-041 req_i=11 for 3 consecutive buffers -> grants 01, 10, 01.
REQ-042 req_i=00, buffer ready -> DISCARD, ram_read_ready_o=1 for 256 accepts, drop_count_o=1, gnt_o stays 00.
REQ-043 Granted index 1 drops req after word 100 -> DISCARD drains 156 words, drop_count_o=1, rd_valid_o[1]=0 from the next cycle.
REQ-044 Backpressure: rd_ready_i[0] toggling 1/0 each cycle -> exactly 256 accepts, no duplicated or missing word (data checked against an incrementing pattern).
REQ-045 rst_ni pulsed low at word 50 -> all outputs at reset values immediately; the next buffer is granted to index 0 with word count restarting at 0.
